// File: rtl/clks_alot_p.sv
// clks_alot_p: types and defaults shared between clock_recovery and
// clock_generation.
//   RATE_COUNTER_WIDTH : default width of phase counters and rate outputs
//   recovered_events_s : one-cycle rising/falling edge pulses of the IO clock
package clks_alot_p;

    localparam int unsigned RATE_COUNTER_WIDTH = 16;

    typedef struct packed {
        logic rising;
        logic falling;
    } recovered_events_s;

endpackage

// File: rtl/common_p.sv
// common_p: shared clock-domain bundle used by blocks that run on one
// system clock with an asynchronous active-low reset.
//   clk_dom_s.clk   : rising-edge system clock
//   clk_dom_s.rst_n : asynchronous active-low reset
package common_p;

    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;

endpackage

// File: rtl/clock_recovery.sv
// clock_recovery: measures a pre-synchronized IO clock against the system
// clock, publishes per-edge events, and locks onto stable high/low phase
// lengths.
//
// Ports:
//   sys_dom_i          - system clock (.clk) and async active-low reset (.rst_n)
//   recovery_en_i      - enables edge events, measurement and lock tracking
//   clear_state_i      - synchronous clear of all recovery state (top priority)
//   io_clk_i           - synchronized IO clock level
//   recovered_events_o - .rising/.falling one-cycle pulses per detected edge
//   high_rate_o        - locked high-phase length in system cycles, else 0
//   low_rate_o         - locked low-phase length in system cycles, else 0
//   high_locked_o      - high phase locked
//   low_locked_o       - low phase locked
//   fully_locked_in_o  - both phases locked
//   lock_lost_o        - one-cycle pulse when a lock drops (mismatch/timeout)
module clock_recovery #(
    parameter int unsigned RATE_COUNTER_WIDTH = clks_alot_p::RATE_COUNTER_WIDTH,
    parameter int unsigned LOCK_COUNT         = 4,
    parameter int unsigned TOLERANCE          = 1
) (
    input  common_p::clk_dom_s             sys_dom_i,
    input  logic                           recovery_en_i,
    input  logic                           clear_state_i,
    input  logic                           io_clk_i,
    output clks_alot_p::recovered_events_s recovered_events_o,
    output logic [RATE_COUNTER_WIDTH-1:0]  high_rate_o,
    output logic [RATE_COUNTER_WIDTH-1:0]  low_rate_o,
    output logic                           high_locked_o,
    output logic                           low_locked_o,
    output logic                           fully_locked_in_o,
    output logic                           lock_lost_o
);

    localparam int unsigned W  = RATE_COUNTER_WIDTH;
    localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

    localparam logic [W-1:0]  COUNT_MAX  = '1;
    localparam logic [MW-1:0] MATCH_FULL = MW'(LOCK_COUNT);
    localparam logic [W:0]    TOL_EXT    = (W+1)'(TOLERANCE);

    typedef struct packed {
        logic [W-1:0]  cand;
        logic [MW-1:0] cnt;
        logic          locked;
    } trk_t;

    logic clk;
    logic rst_n;

    assign clk   = sys_dom_i.clk;
    assign rst_n = sys_dom_i.rst_n;

    logic                           io_clk_q,       io_clk_d;
    logic [W-1:0]                   phase_count_q,  phase_count_d;
    logic                           primed_q,       primed_d;
    trk_t                           high_q,         high_d;
    trk_t                           low_q,          low_d;
    clks_alot_p::recovered_events_s events_q,       events_d;
    logic [W-1:0]                   high_rate_q,    high_rate_d;
    logic [W-1:0]                   low_rate_q,     low_rate_d;
    logic                           fully_locked_q, fully_locked_d;
    logic                           lock_lost_q,    lock_lost_d;

    logic active;
    logic rise;
    logic fall;
    logic edge_seen;
    logic timeout;

    // One measurement step of a phase tracker. The difference is taken one
    // bit wider than the counter so it never wraps.
    function automatic trk_t track(input trk_t cur, input logic [W-1:0] m);
        trk_t       nxt;
        logic [W:0] diff;
        nxt  = cur;
        diff = (m >= cur.cand) ? ({1'b0, m} - {1'b0, cur.cand})
                               : ({1'b0, cur.cand} - {1'b0, m});
        if ((cur.cnt != '0) && (diff <= TOL_EXT)) begin
            if (cur.cnt != MATCH_FULL) begin
                nxt.cnt = cur.cnt + MW'(1);
            end
            if (nxt.cnt == MATCH_FULL) begin
                nxt.locked = 1'b1;
            end
        end else begin
            nxt.cand   = m;
            nxt.cnt    = MW'(1);
            nxt.locked = 1'b0;
        end
        return nxt;
    endfunction

    always_comb begin
        // Sampled level always follows the input so re-enabling or leaving
        // clear never sees a stale level as an edge.
        io_clk_d  = io_clk_i;

        active    = recovery_en_i & ~clear_state_i;
        rise      = active &  io_clk_i & ~io_clk_q;
        fall      = active & ~io_clk_i &  io_clk_q;
        edge_seen = rise | fall;
        timeout   = active & ~edge_seen & (phase_count_q == COUNT_MAX);

        phase_count_d = phase_count_q;
        primed_d      = primed_q;
        high_d        = high_q;
        low_d         = low_q;

        if (clear_state_i) begin
            phase_count_d = '0;
            primed_d      = 1'b0;
            high_d        = '0;
            low_d         = '0;
        end else if (recovery_en_i) begin
            if (edge_seen) begin
                // The count at an edge is the length of the phase just ended:
                // a rising edge closes a low phase, a falling edge a high one.
                if (primed_q) begin
                    if (rise) begin
                        low_d = track(low_q, phase_count_q);
                    end else begin
                        high_d = track(high_q, phase_count_q);
                    end
                end
                phase_count_d = W'(1);
                primed_d      = 1'b1;
            end else if (timeout) begin
                // Stalled IO clock: count stays saturated until the next edge,
                // which then only re-primes.
                high_d.cnt    = '0;
                high_d.locked = 1'b0;
                low_d.cnt     = '0;
                low_d.locked  = 1'b0;
                primed_d      = 1'b0;
            end else begin
                phase_count_d = phase_count_q + W'(1);
            end
        end

        events_d.rising  = rise;
        events_d.falling = fall;
        high_rate_d      = high_d.locked ? high_d.cand : '0;
        low_rate_d       = low_d.locked  ? low_d.cand  : '0;
        fully_locked_d   = high_d.locked & low_d.locked;
        lock_lost_d      = ~clear_state_i &
                           ((high_q.locked & ~high_d.locked) |
                            (low_q.locked  & ~low_d.locked));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_clk_q       <= 1'b0;
            phase_count_q  <= '0;
            primed_q       <= 1'b0;
            high_q         <= '0;
            low_q          <= '0;
            events_q       <= '0;
            high_rate_q    <= '0;
            low_rate_q     <= '0;
            fully_locked_q <= 1'b0;
            lock_lost_q    <= 1'b0;
        end else begin
            io_clk_q       <= io_clk_d;
            phase_count_q  <= phase_count_d;
            primed_q       <= primed_d;
            high_q         <= high_d;
            low_q          <= low_d;
            events_q       <= events_d;
            high_rate_q    <= high_rate_d;
            low_rate_q     <= low_rate_d;
            fully_locked_q <= fully_locked_d;
            lock_lost_q    <= lock_lost_d;
        end
    end

    assign recovered_events_o = events_q;
    assign high_rate_o        = high_rate_q;
    assign low_rate_o         = low_rate_q;
    assign high_locked_o      = high_q.locked;
    assign low_locked_o       = low_q.locked;
    assign fully_locked_in_o  = fully_locked_q;
    assign lock_lost_o        = lock_lost_q;

endmodule

// File: doc/clock_recovery.md
# clock_recovery

Measures an incoming IO clock against the system clock and publishes per-edge events, the measured high and low phase lengths, and lock status. It is the measuring front end that feeds `clock_generation`. Its `recovered_events_o`, `high_rate_o`, `low_rate_o` and `fully_locked_in_o` connect directly to that block's recovery-feedback inputs. All logic runs in the system clock domain; `io_clk_i` arrives pre-synchronized.

## Interface
- `RATE_COUNTER_WIDTH`, default `clks_alot_p::RATE_COUNTER_WIDTH` (16): width of phase counters and rate outputs.
- `LOCK_COUNT`, default 4: consecutive matching measurements required to lock a phase (≥2).
- `TOLERANCE`, default 1: maximum absolute difference, in system cycles, that still counts as a match.

Ports:
- `sys_dom_i` input `common_p::clk_dom_s`: one clock, `.clk`, rising edge; reset `.rst_n`, asynchronous, active-low.
- `recovery_en_i` input 1: enables edge events, measurement and lock tracking.
- `clear_state_i` input 1: synchronous clear of all recovery state.
- `io_clk_i` input 1: synchronized IO clock level.
- `recovered_events_o` output `clks_alot_p::recovered_events_s`: fields `.rising` and `.falling`, each a one-cycle pulse per detected edge.
- `high_rate_o` output `RATE_COUNTER_WIDTH`: locked-in high-phase length in system cycles.
- `low_rate_o` output `RATE_COUNTER_WIDTH`: locked-in low-phase length in system cycles.
- `high_locked_o` output 1: high phase locked.
- `low_locked_o` output 1: low phase locked.
- `fully_locked_in_o` output 1: `high_locked_o & low_locked_o`.
- `lock_lost_o` output 1: one-cycle pulse whenever either lock flag falls due to a mismatch or a timeout.

## Operation
- `io_clk_q` registers `io_clk_i` every cycle, regardless of enable or clear, so re-enabling never produces a spurious edge.
- A rising edge is detected when `io_clk_i & ~io_clk_q`; a falling edge when `~io_clk_i & io_clk_q`. Detection counts only while `recovery_en_i=1` and `clear_state_i=0`.
- `phase_count`:
  - loads 1 on a detected edge;
  - otherwise increments while enabled;
  - saturates at `2^W-1`;
  - holds while `recovery_en_i=0`.
- On a rising edge, `phase_count` is the low-phase measurement. On a falling edge, it is the high-phase measurement.
- `primed` is set by the first detected edge after reset or clear. A measurement taken while `primed=0` is discarded, because the first phase is partial.
- Per-phase tracker, with registers `candidate`, `match_cnt` (range 0..LOCK_COUNT) and `locked`. Each valid measurement M is handled as follows:
  - If `match_cnt≠0` and `|M−candidate| ≤ TOLERANCE`: `match_cnt` increments, saturating at `LOCK_COUNT`. `locked` sets when `match_cnt` reaches `LOCK_COUNT`. `candidate` is unchanged.
  - Otherwise: `candidate←M`, `match_cnt←1`. If `locked` was set, it clears and `lock_lost_o` pulses.
  - The absolute difference is computed with W+1 bits; there is no wrap.
- `high_rate_o` and `low_rate_o` equal the corresponding `candidate` while that phase is locked, and 0 otherwise.
- Timeout: if `phase_count` reaches `2^W-1` (IO clock stalled):
  - both trackers clear (`match_cnt=0`, `locked=0`);
  - `primed` clears;
  - `lock_lost_o` pulses once if either phase was locked;
  - `phase_count` stays saturated until the next edge.
- `clear_state_i` has the highest priority. It clears `phase_count`, `primed`, both trackers and all outputs on the next cycle. No event or `lock_lost_o` pulse is produced in the clear cycle.
- With `recovery_en_i=0`: no events, no measurements, no pulses. Locks and rates hold.

## Timing
- Reset values: all outputs 0; `io_clk_q=0`, `phase_count=0`, `primed=0`, trackers cleared.
- Let cycle N be the first cycle in which `io_clk_i` shows the new level. Then in cycle N+1:
  - the event pulse is on `recovered_events_o`;
  - the tracker update, lock flags, rates and `lock_lost_o` are all visible.
- Event latency is fixed at 1 cycle. All outputs are registered.
- If an IO level is held for H cycles, the measurement is exactly H.
- `fully_locked_in_o` is registered in the same cycle as the lock flag it depends on, not one cycle later.
- If a mismatch and a timeout would both drop lock in one cycle, `lock_lost_o` is a single pulse.
- Asynchronous reset mid-operation returns everything to the reset values immediately. The first edge afterwards is unprimed.

## Test plan
- **Reset:** assert `rst_n=0` mid-stream with `io_clk` toggling → all outputs 0 immediately; first post-reset edge pulses an event but produces no measurement.
- **Steady lock:** `io_clk` 3 high / 5 low, defaults →
  - `high_locked_o` rises at the 4th valid falling event, with `high_rate_o=3`;
  - `low_locked_o` rises at the 4th valid rising event, with `low_rate_o=5`;
  - `fully_locked_in_o` rises with the later of the two flags;
  - `lock_lost_o` never pulses.
- **Jitter within tolerance:** after lock, high alternates 3/4 cycles → stays locked, `high_rate_o=3`.
- **Phase change:** after lock, high becomes 6 →
  - `lock_lost_o` pulses once with `high_locked_o=0` on the first 6-cycle falling event;
  - relocks after 4 measurements with `high_rate_o=6`;
  - low phase unaffected.
- **Stall:** `RATE_COUNTER_WIDTH=8`, locked, then hold `io_clk_i` high for 300 cycles →
  - at `phase_count=255`: both locks drop, `lock_lost_o` pulses once, `primed=0`;
  - next falling edge gives no measurement.
- **Control:**
  - `clear_state_i` pulsed while locked → all outputs 0 next cycle, no event that cycle;
  - `recovery_en_i=0` for 20 cycles with `io_clk` toggling → no events, rates and locks hold, no spurious edge on re-enable.
